// File: rtl/chan_scan_mux.sv
// Registered N-channel word multiplexer with manual select and automatic
// round-robin scanning at a programmable rate, with a hold input.
module chan_scan_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV      = 1000,
  parameter int unsigned SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_flat,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           active_ch,
  output logic                      step
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
  localparam logic [PW-1:0]   TERM    = PW'(DIV - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic [SELW-1:0]  ch_next;
  logic             step_next;
  logic [WIDTH-1:0] y_next;

  // State register: all outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      active_ch <= '0;
      y         <= '0;
      step      <= 1'b0;
    end else begin
      pre       <= pre_next;
      active_ch <= ch_next;
      y         <= y_next;
      step      <= step_next;
    end
  end

  // Next channel / prescaler; hold beats terminal count, manual never steps.
  always_comb begin
    pre_next  = pre;
    ch_next   = active_ch;
    step_next = 1'b0;
    if (!mode) begin
      pre_next = '0;
      ch_next  = (sel > LAST_CH) ? LAST_CH : sel;
    end else if (!hold) begin
      if (pre == TERM) begin
        pre_next  = '0;
        step_next = 1'b1;
        ch_next   = (active_ch == LAST_CH) ? '0 : SELW'(active_ch + SELW'(1));
      end else begin
        pre_next = PW'(pre + PW'(1));
      end
    end
  end

  // ch_next is always in range, so the part-select never leaves in_flat.
  always_comb begin
    y_next = in_flat[int'(ch_next)*WIDTH +: WIDTH];
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Randomized self-checking bench for chan_scan_mux (WIDTH=8, CHANNELS=3, DIV=4)
// against a dwell-counter reference model.
module tb_chan_scan_mux;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DIV      = 4;
  localparam int unsigned SELW     = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] in_flat;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic                      hold;
  logic [WIDTH-1:0]          y;
  logic [SELW-1:0]           active_ch;
  logic                      step;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: channel index, edges spent in the current dwell, outputs.
  int         m_ch   = 0;
  int         m_cnt  = 0;
  logic [7:0] m_y    = 8'h00;
  logic       m_step = 1'b0;

  chan_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .in_flat(in_flat), .mode(mode), .sel(sel),
    .hold(hold), .y(y), .active_ch(active_ch), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word_of(input logic [CHANNELS*WIDTH-1:0] v, input int k);
    return v[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_ch = 0; m_cnt = 0; m_y = 8'h00; m_step = 1'b0;
  endtask

  task automatic load_defaults();
    in_flat = {8'h33, 8'h22, 8'h11};
  endtask

  // Advance one rising edge and update the model from the inputs seen there.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_step = 1'b0;
      if (!mode) begin
        m_cnt = 0;
        m_ch  = (int'(sel) >= CHANNELS) ? CHANNELS - 1 : int'(sel);
      end else if (!hold) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DIV) begin
          m_cnt  = 0;
          m_ch   = (m_ch + 1) % CHANNELS;
          m_step = 1'b1;
        end
      end
      m_y = word_of(in_flat, m_ch);
    end
    #1;
  endtask

  // Start auto scanning from a fresh reset.
  task automatic restart_auto();
    reset = 1'b1; model_reset(); mode = 1'b1; hold = 1'b0; sel = '0;
    load_defaults();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; hold = 1'b0; sel = '0; load_defaults();
    model_reset();
    #2;
    n_checks++; if (y !== 8'h00) $display("FAIL reset_y got %h want 00", y); else n_pass++;
    n_checks++; if (active_ch !== 2'd0) $display("FAIL reset_ch got %0d want 0", active_ch); else n_pass++;
    n_checks++; if (step !== 1'b0) $display("FAIL reset_step got %b want 0", step); else n_pass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_manual();
    int errs;
    mode = 1'b0; hold = 1'b0; load_defaults();
    sel = 2'd1; tick();
    n_checks++; if (y !== 8'h22 || active_ch !== 2'd1 || step !== 1'b0)
      $display("FAIL manual_sel1 got y=%h ch=%0d step=%b want y=22 ch=1 step=0", y, active_ch, step);
    else n_pass++;
    sel = 2'd3; tick();
    n_checks++; if (y !== 8'h33 || active_ch !== 2'd2 || step !== 1'b0)
      $display("FAIL manual_clamp got y=%h ch=%0d step=%b want y=33 ch=2 step=0", y, active_ch, step);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      sel = SELW'($urandom_range(0, 3));
      in_flat = (CHANNELS*WIDTH)'($urandom);
      tick();
      if (y !== m_y || active_ch !== SELW'(m_ch) || step !== 1'b0) begin
        errs++;
        $display("FAIL manual_rand[%0d] got y=%h ch=%0d step=%b want y=%h ch=%0d step=0",
                 i, y, active_ch, step, m_y, m_ch);
      end
    end
    n_checks++; if (errs == 0) n_pass++;
  endtask

  task automatic test_auto_scan();
    int errs;
    logic [7:0] exp_y;
    restart_auto();
    errs = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_y = word_of(in_flat, (e / 4) % 3);
      if (step !== ((e % 4) == 0) || active_ch !== SELW'((e / 4) % 3) || y !== exp_y) begin
        errs++;
        $display("FAIL auto_edge%0d got step=%b ch=%0d y=%h want step=%b ch=%0d y=%h",
                 e, step, active_ch, y, (e % 4) == 0, (e / 4) % 3, exp_y);
      end
    end
    n_checks++; if (errs == 0) n_pass++;
  endtask

  task automatic test_hold();
    int errs;
    logic [SELW-1:0] ch0;
    logic [7:0] y0;
    for (int i = 0; i < 20 && m_cnt != 2; i++) tick();
    n_checks++; if (m_cnt != 2) $display("FAIL hold_sync timeout count=%0d want 2", m_cnt); else n_pass++;
    ch0 = active_ch; y0 = y;
    hold = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step !== 1'b0 || active_ch !== ch0 || y !== y0) begin
        errs++;
        $display("FAIL hold_cycle%0d got step=%b ch=%0d y=%h want step=0 ch=%0d y=%h",
                 i, step, active_ch, y, ch0, y0);
      end
    end
    n_checks++; if (errs == 0) n_pass++;
    hold = 1'b0;
    tick();
    n_checks++; if (step !== 1'b0) $display("FAIL hold_resume1 got step=%b want 0", step); else n_pass++;
    tick();
    n_checks++; if (step !== 1'b1 || active_ch !== SELW'((int'(ch0) + 1) % CHANNELS))
      $display("FAIL hold_resume2 got step=%b ch=%0d want step=1 ch=%0d", step, active_ch, (int'(ch0) + 1) % CHANNELS);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int e;
    for (int i = 0; i < 40 && m_ch != 2; i++) tick();
    n_checks++; if (active_ch !== 2'd2) $display("FAIL midrst_sync got ch=%0d want 2", active_ch); else n_pass++;
    #2;
    reset = 1'b1; model_reset();
    #1;
    n_checks++; if (y !== 8'h00 || active_ch !== 2'd0 || step !== 1'b0)
      $display("FAIL midrst_async got y=%h ch=%0d step=%b want y=00 ch=0 step=0", y, active_ch, step);
    else n_pass++;
    tick();
    reset = 1'b0; mode = 1'b1; hold = 1'b0;
    e = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step === 1'b1) begin e = i; break; end
    end
    n_checks++; if (e != 4) $display("FAIL midrst_first_step got edge %0d want 4", e); else n_pass++;
  endtask

  task automatic test_live_input();
    mode = 1'b0; sel = 2'd1; hold = 1'b0; load_defaults();
    tick();
    in_flat[15:8] = 8'h5A;
    tick();
    n_checks++; if (y !== 8'h5A || active_ch !== 2'd1)
      $display("FAIL live_track got y=%h ch=%0d want y=5a ch=1", y, active_ch);
    else n_pass++;
  endtask

  task automatic test_mode_switch_terminal();
    int e;
    restart_auto();
    for (int i = 0; i < 40 && !(m_ch == 1 && m_cnt == 3); i++) tick();
    n_checks++; if (!(m_ch == 1 && m_cnt == 3) || active_ch !== 2'd1)
      $display("FAIL modesw_sync got ch=%0d count=%0d want ch=1 count=3", active_ch, m_cnt);
    else n_pass++;
    mode = 1'b0; sel = 2'd0;
    tick();
    n_checks++; if (y !== 8'h11 || active_ch !== 2'd0 || step !== 1'b0)
      $display("FAIL modesw_edge got y=%h ch=%0d step=%b want y=11 ch=0 step=0", y, active_ch, step);
    else n_pass++;
    mode = 1'b1;
    e = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step === 1'b1) begin e = i; break; end
    end
    n_checks++; if (e != 4) $display("FAIL modesw_prescaler_cleared got first step at edge %0d want 4", e); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    restart_auto();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) mode = ~mode;
      hold = ($urandom_range(0, 5) == 0);
      sel  = SELW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) in_flat = (CHANNELS*WIDTH)'($urandom);
      reset = ($urandom_range(0, 60) == 0);
      tick();
      if (y !== m_y || active_ch !== SELW'(m_ch) || step !== m_step) begin
        errs++;
        $display("FAIL random[%0d] got y=%h ch=%0d step=%b want y=%h ch=%0d step=%b",
                 i, y, active_ch, step, m_y, m_ch, m_step);
      end
    end
    reset = 1'b0;
    n_checks++; if (errs == 0) n_pass++;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; hold = 1'b0; sel = '0; in_flat = '0;
    @(negedge clk);
    test_reset();
    test_manual();
    test_auto_scan();
    test_hold();
    test_reset_mid_scan();
    test_live_input();
    test_mode_switch_terminal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
